// File: rtl/step_ctrl_pkg.sv
// step_ctrl_pkg
// Shared types and constants for the step controller.
//   mode_t      : operating mode of the step controller (MANUAL / AUTO)
//   STEP_CNT_W  : width of the issued-step counter shown on the board LEDs
package step_ctrl_pkg;

   typedef enum logic {
      MANUAL = 1'b0,
      AUTO   = 1'b1
   } mode_t;

   localparam int STEP_CNT_W = 8;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce
// Two-flop synchronizer followed by a counting debouncer for one raw button.
// Ports:
//   clock  in   system clock, all state on rising edge
//   reset  in   asynchronous active-low reset
//   btn    in   raw asynchronous active-high button
//   level  out  debounced button level (registered)
//   press  out  one-cycle pulse on a rising edge of the debounced level (registered)
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic btn,
   output logic level,
   output logic press
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q;
   logic             sync2_q;
   logic             level_q;
   logic             level_d;
   logic             press_q;
   logic             press_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // The counter tracks how many consecutive samples disagreed with the
   // accepted level; the sample that completes the run flips the level on
   // the same edge, so the press pulse lines up with the level change.
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
      press_d = level_d & ~level_q;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         press_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn;
         sync2_q <= sync1_q;
         level_q <= level_d;
         press_q <= press_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level = level_q;
   assign press = press_q;

endmodule

// File: rtl/step_ctrl.sv
// step_ctrl
// Turns the raw step and mode buttons into a single-cycle step enable for
// the even-sequence counter, with manual single-stepping and a prescaled
// free-running auto mode.
// Ports:
//   clock       in   system clock, all state on rising edge
//   reset       in   asynchronous active-low reset
//   btn_step    in   raw step button (active high)
//   btn_mode    in   raw mode-toggle button (active high)
//   step        out  one-cycle enable to the counter FSM
//   running     out  1 = AUTO, 0 = MANUAL
//   step_count  out  number of step pulses issued, modulo 256
module step_ctrl
   import step_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int PRESCALE        = 5
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  btn_step,
   input  logic                  btn_mode,
   output logic                  step,
   output logic                  running,
   output logic [STEP_CNT_W-1:0] step_count
);

   localparam int PS_W = $clog2(PRESCALE);
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

   logic                  step_press;
   logic                  mode_press;
   // Only the press pulses drive the FSM; the debounced levels are left idle.
   logic                  step_level_unused;
   logic                  mode_level_unused;

   mode_t                 state_q;
   mode_t                 state_d;
   logic                  running_q;
   logic                  running_d;
   logic                  step_q;
   logic                  step_d;
   logic [PS_W-1:0]       presc_q;
   logic [PS_W-1:0]       presc_d;
   logic [STEP_CNT_W-1:0] count_q;
   logic [STEP_CNT_W-1:0] count_d;

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_step_db (
      .clock(clock),
      .reset(reset),
      .btn  (btn_step),
      .level(step_level_unused),
      .press(step_press)
   );

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_mode_db (
      .clock(clock),
      .reset(reset),
      .btn  (btn_mode),
      .level(mode_level_unused),
      .press(mode_press)
   );

   // A mode press takes priority: it toggles the mode, restarts the
   // prescaler and suppresses any step in that cycle. The prescaler only
   // runs in AUTO, so the first auto step lands PRESCALE cycles after entry.
   always_comb begin
      state_d = state_q;
      presc_d = '0;
      step_d  = 1'b0;
      if (mode_press) begin
         state_d = (state_q == AUTO) ? MANUAL : AUTO;
      end else if (state_q == AUTO) begin
         step_d  = (presc_q == PS_LAST);
         presc_d = step_d ? '0 : presc_q + PS_W'(1);
      end else begin
         step_d = step_press;
      end
      running_d = (state_d == AUTO);
      count_d   = step_d ? count_q + STEP_CNT_W'(1) : count_q;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= MANUAL;
         running_q <= 1'b0;
         step_q    <= 1'b0;
         presc_q   <= '0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         running_q <= running_d;
         step_q    <= step_d;
         presc_q   <= presc_d;
         count_q   <= count_d;
      end
   end

   assign step       = step_q;
   assign running    = running_q;
   assign step_count = count_q;

endmodule

// File: tb/tb_step_ctrl.sv
// tb_step_ctrl
// Directed bench for step_ctrl with DEBOUNCE_CYCLES=4, PRESCALE=5.
// Inputs change on the falling edge or 1ns after a rising edge; outputs are
// read 1ns after a rising edge. Edge k is the first rising edge that samples
// a newly raised button.
module tb_step_ctrl;

   logic       clock;
   logic       reset;
   logic       btn_step;
   logic       btn_mode;
   logic       step;
   logic       running;
   logic [7:0] step_count;

   int assertCount = 0;
   int failCount   = 0;
   int pulseCount  = 0;
   int doubleCount = 0;
   logic prevStep  = 1'b0;

   step_ctrl #(
      .DEBOUNCE_CYCLES(4),
      .PRESCALE       (5)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .btn_step  (btn_step),
      .btn_mode  (btn_mode),
      .step      (step),
      .running   (running),
      .step_count(step_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Independent pulse watcher: counts step pulses and flags back-to-back ones.
   always @(negedge clock) begin
      if (reset) begin
         if (step) pulseCount++;
         if (step && prevStep) doubleCount++;
         prevStep = step;
      end else begin
         prevStep = 1'b0;
      end
   end

   task automatic checkOutput(input string tag, input int observed, input int expected);
      assertCount++;
      if (observed != expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // Raise the selected buttons at a falling edge for exactly holdCycles
   // sampling edges, then release them.
   task automatic applyStimulus(input logic s, input logic m, input int holdCycles);
      @(negedge clock);
      btn_step = s;
      btn_mode = m;
      repeat (holdCycles) @(posedge clock);
      #1;
      btn_step = 1'b0;
      btn_mode = 1'b0;
   endtask

   initial begin
      reset    = 1'b0;
      btn_step = 1'b0;
      btn_mode = 1'b0;

      // Reset state
      tick(3);
      checkOutput("rst_step", step, 0);
      checkOutput("rst_running", running, 0);
      checkOutput("rst_count", step_count, 0);
      @(negedge clock);
      reset = 1'b1;
      tick(10);
      checkOutput("idle_no_pulse", pulseCount, 0);

      // Clean press: step high for one cycle at edge k+6
      @(negedge clock);
      btn_step = 1'b1;
      tick(6);
      checkOutput("clean_k5_step", step, 0);
      tick(1);
      checkOutput("clean_k6_step", step, 1);
      tick(1);
      checkOutput("clean_k7_step", step, 0);
      checkOutput("clean_count", step_count, 1);
      tick(4);
      btn_step = 1'b0;
      tick(15);
      checkOutput("clean_release_count", step_count, 1);
      checkOutput("clean_pulses", pulseCount, 1);

      // Glitch: 3 cycles rejected, 4 cycles accepted
      applyStimulus(1'b1, 1'b0, 3);
      tick(15);
      checkOutput("glitch3_count", step_count, 1);
      applyStimulus(1'b1, 1'b0, 4);
      tick(15);
      checkOutput("glitch4_count", step_count, 2);

      // Auto mode
      @(negedge clock);
      btn_mode = 1'b1;
      tick(6);
      checkOutput("auto_k5_running", running, 0);
      tick(1);
      checkOutput("auto_k6_running", running, 1);
      checkOutput("auto_k6_step", step, 0);
      btn_mode = 1'b0;
      btn_step = 1'b1;
      tick(4);
      checkOutput("auto_k10_step", step, 0);
      tick(1);
      checkOutput("auto_k11_step", step, 1);
      tick(1);
      checkOutput("auto_k12_step", step, 0);
      checkOutput("auto_k12_count", step_count, 3);
      btn_step = 1'b0;
      tick(4);
      checkOutput("auto_k16_step", step, 1);
      tick(1);
      checkOutput("auto_k17_count", step_count, 4);
      tick(14);
      checkOutput("auto_k31_step", step, 1);
      tick(1);
      checkOutput("auto_k32_count", step_count, 7);
      btn_mode = 1'b1;
      tick(6);
      checkOutput("auto_exit_k38_running", running, 1);
      checkOutput("auto_exit_k38_count", step_count, 8);
      tick(1);
      checkOutput("auto_exit_k39_running", running, 0);
      btn_mode = 1'b0;
      tick(20);
      checkOutput("manual_again_count", step_count, 8);
      checkOutput("manual_again_step", step, 0);
      checkOutput("auto_pulses", pulseCount, 8);

      // Simultaneous press: mode wins, no manual step
      @(negedge clock);
      btn_step = 1'b1;
      btn_mode = 1'b1;
      tick(7);
      checkOutput("simul_k6_running", running, 1);
      checkOutput("simul_k6_step", step, 0);
      btn_step = 1'b0;
      btn_mode = 1'b0;
      tick(2);
      checkOutput("simul_k8_count", step_count, 8);
      tick(3);
      checkOutput("simul_k11_step", step, 1);
      tick(5);
      checkOutput("simul_k16_step", step, 1);
      tick(5);
      checkOutput("simul_k21_step", step, 1);

      // Asynchronous reset mid-cycle, right after the third auto step
      #2;
      reset = 1'b0;
      #1;
      checkOutput("async_rst_step", step, 0);
      checkOutput("async_rst_running", running, 0);
      checkOutput("async_rst_count", step_count, 0);
      tick(3);
      @(negedge clock);
      reset = 1'b1;
      tick(20);
      checkOutput("post_rst_step", step, 0);
      checkOutput("post_rst_running", running, 0);
      checkOutput("post_rst_count", step_count, 0);
      checkOutput("post_rst_pulses", pulseCount, 10);

      // Wrap: 256 manual steps
      for (int i = 0; i < 255; i++) begin
         applyStimulus(1'b1, 1'b0, 5);
         tick(8);
      end
      tick(4);
      checkOutput("wrap_count_255", step_count, 255);
      @(negedge clock);
      btn_step = 1'b1;
      tick(7);
      checkOutput("wrap_k6_step", step, 1);
      tick(1);
      checkOutput("wrap_k7_step", step, 0);
      checkOutput("wrap_count_0", step_count, 0);
      btn_step = 1'b0;
      tick(15);
      checkOutput("wrap_pulses", pulseCount, 266);

      // Button held through reset release counts as one fresh press
      btn_step = 1'b1;
      #2;
      reset = 1'b0;
      tick(3);
      @(negedge clock);
      reset = 1'b1;
      tick(20);
      checkOutput("held_rst_count", step_count, 1);
      btn_step = 1'b0;
      tick(15);
      checkOutput("held_rst_pulses", pulseCount, 267);
      checkOutput("no_double_pulse", doubleCount, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/step_ctrl.md
# step_ctrl

Upstream stage of the even-sequence counter FSM. Turns two raw push-buttons into a single-cycle `step` enable that advances the counter by one state. Supports manual single-stepping and a free-running auto mode paced by a prescaler. Also exposes a mode indicator and a running count of issued steps for board LEDs.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles required to accept a button level change. Must be ≥1.
- `PRESCALE`, default 5: auto-mode step period in clock cycles. Must be ≥2.

Ports:
- `clock`  in  1  single system clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low; asserting low clears all state immediately.
- `btn_step`  in  1  raw, asynchronous, active-high step button.
- `btn_mode`  in  1  raw, asynchronous, active-high mode-toggle button.
- `step`  out  1  one-cycle enable to the counter FSM.
- `running`  out  1  1 = AUTO mode, 0 = MANUAL.
- `step_count`  out  8  number of `step` pulses issued, modulo 256.

## Operation
- Each button passes through its own two-flop synchronizer and then a debouncer.
  - The debounced level changes only after the synchronized input has differed from it for `DEBOUNCE_CYCLES` consecutive cycles.
  - Any agreeing sample resets the debounce counter.
- A rising edge of a debounced level is a "press". Falling edges have no effect.
- Mode FSM, states `MANUAL` and `AUTO`. Reset state is `MANUAL`.
  - A mode press toggles the state.
  - `running` is registered and equals (state == AUTO).
- MANUAL:
  - A step press produces exactly one `step` pulse.
  - The prescaler is held at 0.
- AUTO:
  - The prescaler counts 0..PRESCALE-1 and wraps.
  - `step` is asserted in the cycle after the prescaler equals PRESCALE-1.
  - Step presses are ignored.
- Entering either mode clears the prescaler to 0, so the first auto step comes PRESCALE cycles after the `running` rise.
- A mode press and a step press on the same cycle: the mode toggle wins and the step press is discarded.
- `step_count` increments by 1 on every cycle where `step`=1 and wraps 255→0.
- Reset values: `step`=0, `running`=0, `step_count`=0. Synchronizers, debounced levels, debounce counters and prescaler are all 0.
- A button held high through reset release is seen as a fresh press after debounce (one step, or one mode toggle).

## Timing
- All outputs are registered, with no combinational input-to-output path.
- Manual step latency: if `btn_step` is first sampled high at edge k and held, `step` is high for exactly one cycle, from edge k+DEBOUNCE_CYCLES+2 to the next edge.
- Mode latency: `running` toggles at edge k+DEBOUNCE_CYCLES+2 under the same rule.
- Pulses shorter than DEBOUNCE_CYCLES synchronized cycles produce no press.
- Auto mode: `step` pulses are exactly PRESCALE cycles apart, each one cycle wide. `step` is never high on two consecutive cycles in any mode.
- Reset assertion clears outputs asynchronously. Deassertion is taken synchronously at the next edge, with no partial-cycle pulse.
- Reset asserted mid-debounce or mid-prescale discards all progress.

## Structure
- Shared package `step_ctrl_pkg` holds:
  - `typedef enum logic {MANUAL, AUTO} mode_t`
  - the step-count width constant `STEP_CNT_W = 8`.
- Sub-module `btn_debounce`, instantiated twice:
  - contents: synchronizer, debounce counter of width $clog2(DEBOUNCE_CYCLES+1), debounced level, and registered rising-edge `press` output.
  - parameter: `DEBOUNCE_CYCLES`
  - ports: `clock`, `reset`, `btn`, `level`, `press`.
- The top level holds the mode FSM, prescaler of width $clog2(PRESCALE), and `step_count`.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and PRESCALE=5.
- Reset: after 3 auto steps, drive `reset`=0 mid-cycle. Outputs go to `step`=0, `running`=0, `step_count`=0 before the next edge. After release, no `step` appears without a press.
- Clean press: `btn_step` high from edge 10 for 12 cycles. Exactly one `step`, high from edge 16 to edge 17. `step_count`=1. Release produces nothing.
- Glitch: `btn_step` high for 3 cycles, then low. No `step`, `step_count` stays 0. Repeat with 4 cycles and expect one `step`.
- Auto mode: press `btn_mode`. `running`=1, then `step` pulses exactly 5 cycles apart; pressing `btn_step` in this mode adds no pulses. After 20 cycles from the first step, `step_count`=5. A second mode press gives `running`=0 and pulses stop.
- Simultaneous: both buttons rise on the same edge and are held. `running` toggles to 1 at edge k+6 and no manual `step` pulse occurs.
- Wrap: issue 256 manual steps. `step_count` reads 255 then 0, and `step` is still single-cycle.
